count_sequencer: RTL and testbench

- Controller that sequences a WIDTH-bit binary event counter: start, stop, pause, programmable terminal count, up/down direction, one-shot or auto-reload.
- Replaces free-running counters where software or a top-level FSM must know when a count sequence has completed.
- Sits between board controls or an upstream FSM and the display or next-stage logic.
- Fully synchronous to a single clock; the counter register is internal, with no derived or rippled clocks.

---
 rtl/count_sequencer.sv | 134 +++++++++++++
 tb/tb_count_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Sequencer for a WIDTH-bit event counter: start/stop/pause, programmable
// terminal count, up/down direction, one-shot or auto-reload with a reload tally.
module count_sequencer #(
    parameter int WIDTH = 3,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             up_down,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WRAPW-1:0] wraps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
    localparam logic [WRAPW-1:0] WRP_ZERO = {WRAPW{1'b0}};
    localparam logic [WRAPW-1:0] WRP_ONE  = WRAPW'(1'b1);
    localparam logic [WRAPW-1:0] WRP_MAX  = {WRAPW{1'b1}};

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             dir_q;
    logic             reload_q;
    logic             done_q;
    logic [WRAPW-1:0] wraps_q;

    logic [WIDTH-1:0] term_d;
    logic [WIDTH-1:0] seed_d;
    logic [WIDTH-1:0] step_d;
    logic [WRAPW-1:0] wraps_inc_d;

    // Terminal/seed/step values derived only from the latched sequence settings
    always_comb begin
        term_d      = CNT_ZERO;
        seed_d      = CNT_ZERO;
        step_d      = count_q;
        wraps_inc_d = wraps_q;
        if (dir_q) begin
            term_d = limit_q;
            seed_d = CNT_ZERO;
            step_d = count_q + CNT_ONE;
        end else begin
            term_d = CNT_ZERO;
            seed_d = limit_q;
            step_d = count_q - CNT_ONE;
        end
        if (wraps_q != WRP_MAX) begin
            wraps_inc_d = wraps_q + WRP_ONE;
        end else begin
            wraps_inc_d = WRP_MAX;
        end
    end

    // Sequencer FSM; stop overrides start, start overrides pause, pause overrides counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            limit_q  <= CNT_ZERO;
            dir_q    <= 1'b0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            wraps_q  <= WRP_ZERO;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                count_q <= CNT_ZERO;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            limit_q  <= limit;
                            dir_q    <= up_down;
                            reload_q <= auto_reload;
                            count_q  <= up_down ? CNT_ZERO : limit;
                            wraps_q  <= WRP_ZERO;
                            state_q  <= ST_RUN;
                        end else begin
                            state_q <= state_q;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSE;
                        end else if (count_q == term_d) begin
                            done_q <= 1'b1;
                            if (reload_q) begin
                                count_q <= seed_d;
                                wraps_q <= wraps_inc_d;
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            count_q <= step_d;
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_PAUSE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        count_q <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = done_q;
    assign wraps = wraps_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized scoreboard bench for count_sequencer against a sequence-position model.
module tb_count_sequencer;

    localparam int WIDTH = 3;
    localparam int WRAPW = 8;
    localparam int WRAP_MAX = (1 << WRAPW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic             up_down = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [WRAPW-1:0] wraps;

    count_sequencer #(.WIDTH(WIDTH), .WRAPW(WRAPW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .up_down(up_down), .auto_reload(auto_reload), .limit(limit),
        .count(count), .busy(busy), .done(done), .wraps(wraps)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit busy;
        bit done;
        int wr;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a sequence is a list of positions 0..lim; value depends on direction
    bit m_active, m_paused, m_dir, m_rel, m_done;
    int m_lim, m_pos, m_cnt, m_wr;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int seq_val(int p);
        return m_dir ? p : (m_lim - p);
    endfunction

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_dir = 0; m_rel = 0; m_done = 0;
        m_lim = 0; m_pos = 0; m_cnt = 0; m_wr = 0;
    endtask

    task automatic model_step(bit s, bit st, bit p, bit ud, bit ar, int l);
        m_done = 0;
        if (st) begin
            m_active = 0;
            m_paused = 0;
            m_cnt    = 0;
        end else if (!m_active && s) begin
            m_lim = l; m_dir = ud; m_rel = ar;
            m_pos = 0; m_cnt = seq_val(0);
            m_wr = 0; m_active = 1; m_paused = 0;
        end else if (m_active && m_paused) begin
            if (!p) m_paused = 0;
        end else if (m_active) begin
            if (p) begin
                m_paused = 1;
            end else if (m_pos == m_lim) begin
                m_done = 1;
                if (m_rel) begin
                    m_pos = 0;
                    m_cnt = seq_val(0);
                    m_wr  = (m_wr < WRAP_MAX) ? m_wr + 1 : WRAP_MAX;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_pos = m_pos + 1;
                m_cnt = seq_val(m_pos);
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.cnt = m_cnt; e.busy = m_active; e.done = m_done; e.wr = m_wr;
        sb_q.push_back(e);
    endtask

    task automatic cycle(bit s, bit st, bit p, bit ud, bit ar, int l, bit r);
        @(negedge clk);
        rst = r; start = s; stop = st; pause = p;
        up_down = ud; auto_reload = ar; limit = l[WIDTH-1:0];
        if (!r) model_reset();
        else model_step(s, st, p, ud, ar, l);
        push_exp();
    endtask

    task automatic idle(int n, int l);
        repeat (n) cycle(0, 0, 0, 0, 0, l, 1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_done", int'(done), 0);
        chk("async_wraps", int'(wraps), 0);
        chk("async_busy", int'(busy), 0);
        model_reset();
        push_exp();
    endtask

    // Monitor: compares every post-edge output against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count", int'(count), e.cnt);
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
                chk("wraps", int'(wraps), e.wr);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wraps", int'(wraps), 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // One-shot up to 5, inputs changed after start
        cycle(1, 0, 0, 1, 0, 5, 1);
        repeat (8) cycle(0, 0, 0, 0, 1, 2, 1);

        // Down, auto-reload, limit 3
        cycle(1, 0, 0, 0, 1, 3, 1);
        idle(12, 7);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Pause for 3 cycles at count 2
        cycle(1, 0, 0, 1, 0, 6, 1);
        idle(2, 6);
        repeat (3) cycle(0, 0, 1, 1, 0, 6, 1);
        idle(8, 6);

        // Stop together with start at count 4, then restart with new values
        cycle(1, 0, 0, 1, 0, 7, 1);
        idle(4, 7);
        cycle(1, 1, 0, 1, 1, 2, 1);
        cycle(1, 0, 0, 0, 0, 4, 1);
        idle(6, 4);

        // Limit changes and start while running are ignored
        cycle(1, 0, 0, 1, 0, 5, 1);
        idle(2, 2);
        cycle(1, 0, 0, 0, 1, 2, 1);
        idle(6, 2);

        // Async reset mid-count with wraps nonzero, then limit 0 one-shot
        cycle(1, 0, 0, 0, 1, 3, 1);
        idle(10, 3);
        async_reset();
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 1, 0, 0, 1);
        idle(3, 0);

        // Limit 0 auto-reload: wraps saturates
        cycle(1, 0, 0, 1, 1, 0, 1);
        idle(300, 0);
        cycle(0, 1, 0, 0, 0, 0, 1);

        // Random phase
        repeat (1500) begin
            cycle(($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 6) == 0,
                  $urandom % 2, $urandom % 2, int'($urandom % 8), ($urandom % 200) != 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
